elite_spi_master: RTL and testbench

ELITE_SPI_MASTER -- requirements
Module: elite_spi_master

---
 rtl/elite_spi_master_if.sv | 21 ++
 rtl/elite_spi_master.sv | 117 +++++++++++
 tb/tb_elite_spi_master.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/elite_spi_master_if.sv
// elite_spi_master_if: transmit FIFO host port, receive port and SPI pins of elite_spi_master
interface elite_spi_master_if;
  logic [7:0] MSPI_Tx_Byte;
  logic       MSPI_Tx_Strobe;
  logic       MSPI_Tx_Full;
  logic       MSPI_Busy;
  logic [7:0] MSPI_Rx_Byte;
  logic       MSPI_Rx_Valid;
  logic       MSPI_SCLK;
  logic       MSPI_CSEL;
  logic       MSPI_MOSI;
  logic       MSPI_MISO;
  modport master (
    input  MSPI_Tx_Byte, MSPI_Tx_Strobe, MSPI_MISO,
    output MSPI_Tx_Full, MSPI_Busy, MSPI_Rx_Byte, MSPI_Rx_Valid, MSPI_SCLK, MSPI_CSEL, MSPI_MOSI
  );
  modport slave (
    output MSPI_Tx_Byte, MSPI_Tx_Strobe, MSPI_MISO,
    input  MSPI_Tx_Full, MSPI_Busy, MSPI_Rx_Byte, MSPI_Rx_Valid, MSPI_SCLK, MSPI_CSEL, MSPI_MOSI
  );
endinterface

// File: rtl/elite_spi_master.sv
// elite_spi_master: mode-0 SPI master with byte transmit FIFO, continuous frames while bytes are queued
module elite_spi_master #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16
) (
  input logic MClk,
  input logic MSPI_Rst_Flag,
  elite_spi_master_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
  state_t r_state, w_state;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_cnt, w_cnt;
  logic [7:0] r_ph, r_tx, w_tx, r_rx, w_rx, r_rx_byte, w_head;
  logic [2:0] r_bit, w_bit;
  logic [1:0] r_miso;
  logic r_full, r_valid, w_valid, r_sclk, w_sclk, r_csel, w_csel, r_mosi, w_mosi;
  logic w_push, w_pop, w_last, w_avail;
  assign w_push  = bus.MSPI_Tx_Strobe && !r_full;
  assign w_avail = r_cnt != '0;
  assign w_last  = r_ph == 8'(CLK_DIV - 1);
  assign w_head  = r_mem[r_rd];
  assign w_cnt   = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  assign bus.MSPI_Tx_Full  = r_full;
  assign bus.MSPI_Busy     = (r_state != IDLE) || w_avail;
  assign bus.MSPI_Rx_Byte  = r_rx_byte;
  assign bus.MSPI_Rx_Valid = r_valid;
  assign bus.MSPI_SCLK     = r_sclk;
  assign bus.MSPI_CSEL     = r_csel;
  assign bus.MSPI_MOSI     = r_mosi;
  always_comb begin
    w_state = r_state;
    w_pop   = 1'b0;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_bit   = r_bit;
    w_valid = 1'b0;
    w_sclk  = r_sclk;
    w_csel  = r_csel;
    w_mosi  = r_mosi;
    unique case (r_state)
      IDLE: if (w_avail) begin
        w_state = SETUP;
        w_pop   = 1'b1;
        w_tx    = w_head;
        w_mosi  = w_head[7];
        w_csel  = 1'b0;
        w_bit   = 3'd0;
      end
      SETUP: w_state = w_last ? LOW : SETUP;
      LOW: if (w_last) begin
        w_state = HIGH;
        w_sclk  = 1'b1;
      end
      HIGH: if (w_last) begin
        w_sclk  = 1'b0;
        w_rx    = {r_rx[6:0], r_miso[1]};
        w_tx    = {r_tx[6:0], 1'b0};
        w_bit   = r_bit + 3'd1;
        w_mosi  = r_tx[6];
        w_state = LOW;
        // Byte boundary: chain straight into the next queued byte without releasing CSEL
        if (r_bit == 3'd7) begin
          w_valid = 1'b1;
          w_pop   = w_avail;
          w_state = w_avail ? LOW : HOLD;
          w_tx    = w_avail ? w_head : 8'h00;
          w_mosi  = w_avail && w_head[7];
        end
      end
      HOLD: if (w_last) begin
        w_state = GAP;
        w_csel  = 1'b1;
        w_mosi  = 1'b0;
      end
      GAP: w_state = w_last ? IDLE : GAP;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge MClk) if (w_push) r_mem[r_wr] <= bus.MSPI_Tx_Byte;
  always_ff @(posedge MClk or posedge MSPI_Rst_Flag)
    if (MSPI_Rst_Flag) begin
      r_state   <= IDLE;
      r_ph      <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_byte <= '0;
      r_bit     <= '0;
      r_valid   <= 1'b0;
      r_sclk    <= 1'b0;
      r_csel    <= 1'b1;
      r_mosi    <= 1'b0;
      r_miso    <= '0;
    end else begin
      r_state   <= w_state;
      r_ph      <= (w_state != r_state || r_state == IDLE) ? '0 : r_ph + 8'd1;
      r_wr      <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd      <= w_pop ? r_rd + 1'b1 : r_rd;
      r_cnt     <= w_cnt;
      r_full    <= w_cnt == (AW + 1)'(FIFO_DEPTH);
      r_tx      <= w_tx;
      r_rx      <= w_rx;
      r_rx_byte <= w_valid ? w_rx : r_rx_byte;
      r_bit     <= w_bit;
      r_valid   <= w_valid;
      r_sclk    <= w_sclk;
      r_csel    <= w_csel;
      r_mosi    <= w_mosi;
      r_miso    <= {r_miso[0], bus.MSPI_MISO};
    end
endmodule

// File: tb/tb_elite_spi_master.sv
// tb_elite_spi_master: directed and random frames against a byte-level SPI slave and frame model
module tb_elite_spi_master;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  elite_spi_master_if bus();
  elite_spi_master #(.CLK_DIV(4), .FIFO_DEPTH(16)) dut (.MClk(clk), .MSPI_Rst_Flag(rst), .bus(bus));
  int errs = 0, checks = 0;
  byte unsigned resp [32];
  int s_idx = 0, s_n = 0;
  logic [7:0] s_sh = 8'h00;
  assign bus.MSPI_MISO = s_sh[7];
  // Slave: presents response byte MSB first, changes data after each SCLK falling edge
  always @(negedge bus.MSPI_CSEL) begin
    s_idx = 0;
    s_n = 0;
    s_sh = resp[0];
  end
  always @(negedge bus.MSPI_SCLK) if (!bus.MSPI_CSEL) begin
    s_n++;
    if (s_n == 8) begin
      s_n = 0;
      s_idx++;
      s_sh = (s_idx < 32) ? resp[s_idx] : 8'h00;
    end else s_sh = s_sh << 1;
  end
  int cyc = 0, low_len = 0, sclk_n = 0, mosi_viol = 0, mosi_hi = 0;
  logic p_sclk = 1'b0, p_csel = 1'b1;
  logic mosi_q[$];
  int frame_q[$], rx_t[$], sclk_t[$];
  byte unsigned rx_q[$];
  always @(negedge clk) begin
    cyc++;
    if (!bus.MSPI_CSEL) low_len++;
    else if (!p_csel) begin
      frame_q.push_back(low_len);
      low_len = 0;
    end
    if (bus.MSPI_SCLK && !p_sclk) begin
      sclk_n++;
      mosi_q.push_back(bus.MSPI_MOSI);
      sclk_t.push_back(cyc);
    end
    if (bus.MSPI_CSEL && bus.MSPI_MOSI) mosi_viol++;
    if (bus.MSPI_MOSI) mosi_hi++;
    if (bus.MSPI_Rx_Valid) begin
      rx_q.push_back(bus.MSPI_Rx_Byte);
      rx_t.push_back(cyc);
    end
    p_sclk = bus.MSPI_SCLK;
    p_csel = bus.MSPI_CSEL;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic mon_clear();
    mosi_q.delete(); frame_q.delete(); rx_q.delete(); rx_t.delete(); sclk_t.delete();
    sclk_n = 0; mosi_viol = 0; mosi_hi = 0; low_len = 0;
  endtask
  task automatic set_resp(input byte unsigned rs[$]);
    for (int i = 0; i < 32; i++) resp[i] = (i < rs.size()) ? rs[i] : 8'h00;
  endtask
  task automatic push_burst(input byte unsigned tx[$]);
    foreach (tx[i]) begin
      @(negedge clk);
      bus.MSPI_Tx_Strobe = 1'b1;
      bus.MSPI_Tx_Byte = tx[i];
    end
    @(negedge clk);
    bus.MSPI_Tx_Strobe = 1'b0;
  endtask
  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.MSPI_Busy || !bus.MSPI_CSEL) && n < budget);
    chk("idle_timeout", 32'(n >= budget), 0);
    @(posedge clk);
  endtask
  // Expected frame: one CSEL window of 4 + 64*n + 4 cycles, 8*n SCLK pulses 8 cycles apart,
  // MOSI bytes equal tx MSB first, Rx bytes equal slave responses 64 cycles apart
  task automatic check_frame(input string t, input byte unsigned tx[$], input byte unsigned rs[$]);
    int n = tx.size(), bad = 0;
    byte unsigned b;
    chk({t, "_frames"}, frame_q.size(), 1);
    chk({t, "_csel_len"}, frame_q.size() > 0 ? frame_q[0] : -1, 8 + 64 * n);
    chk({t, "_sclk_n"}, sclk_n, 8 * n);
    for (int i = 1; i < sclk_t.size(); i++) if (sclk_t[i] - sclk_t[i-1] != 8) bad++;
    chk({t, "_sclk_period"}, bad, 0);
    for (int i = 0; i < n; i++) begin
      b = 0;
      for (int k = 0; k < 8; k++) b = {b[6:0], (8*i+k < mosi_q.size()) ? mosi_q[8*i+k] : 1'b0};
      chk($sformatf("%s_mosi%0d", t, i), b, tx[i]);
    end
    chk({t, "_rx_n"}, rx_q.size(), n);
    for (int i = 0; i < rx_q.size() && i < n; i++) chk($sformatf("%s_rx%0d", t, i), rx_q[i], rs[i]);
    bad = 0;
    for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] - rx_t[i-1] != 64) bad++;
    chk({t, "_rx_spacing"}, bad, 0);
    chk({t, "_mosi_csel"}, mosi_viol, 0);
  endtask
  task automatic run_frame(input string t, input byte unsigned tx[$], input byte unsigned rs[$]);
    set_resp(rs);
    mon_clear();
    push_burst(tx);
    wait_idle(64 * tx.size() + 200);
    check_frame(t, tx, rs);
  endtask
  initial begin
    byte unsigned tx[$], rs[$];
    int n;
    bus.MSPI_Tx_Strobe = 1'b0;
    bus.MSPI_Tx_Byte = 8'h00;
    #12;
    chk("rst_sclk", bus.MSPI_SCLK, 0);
    chk("rst_csel", bus.MSPI_CSEL, 1);
    chk("rst_mosi", bus.MSPI_MOSI, 0);
    chk("rst_rx", bus.MSPI_Rx_Byte, 0);
    chk("rst_valid", bus.MSPI_Rx_Valid, 0);
    chk("rst_busy", bus.MSPI_Busy, 0);
    chk("rst_full", bus.MSPI_Tx_Full, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    run_frame("a5", '{8'hA5}, '{8'h3C});
    chk("a5_rx_byte", bus.MSPI_Rx_Byte, 8'h3C);
    run_frame("seq3", '{8'h01, 8'h02, 8'h03}, '{8'h96, 8'h0F, 8'hE1});
    run_frame("miso1", '{8'h00}, '{8'hFF});
    chk("miso1_mosi_low", mosi_hi, 0);
    chk("miso1_rx_byte", bus.MSPI_Rx_Byte, 8'hFF);
    run_frame("miso0", '{8'h00}, '{8'h00});
    chk("miso0_mosi_low", mosi_hi, 0);
    chk("miso0_rx_byte", bus.MSPI_Rx_Byte, 8'h00);
    for (int f = 0; f < 4; f++) begin
      tx.delete(); rs.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        tx.push_back(8'($urandom));
        rs.push_back(8'($urandom));
      end
      run_frame($sformatf("rnd%0d", f), tx, rs);
    end
    tx.delete(); rs.delete();
    for (int i = 0; i < 18; i++) tx.push_back(8'($urandom));
    for (int i = 0; i < 17; i++) rs.push_back(8'($urandom));
    set_resp(rs);
    mon_clear();
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 17) chk("full_after17", bus.MSPI_Tx_Full, 1);
      bus.MSPI_Tx_Strobe = 1'b1;
      bus.MSPI_Tx_Byte = tx[i];
    end
    @(negedge clk);
    bus.MSPI_Tx_Strobe = 1'b0;
    chk("full_after18", bus.MSPI_Tx_Full, 1);
    wait_idle(3000);
    tx.pop_back();
    check_frame("fifo17", tx, rs);
    chk("fifo17_full_clear", bus.MSPI_Tx_Full, 0);
    set_resp('{8'h5A, 8'hC3, 8'h3C});
    mon_clear();
    push_burst('{8'h81});
    n = 0;
    while (sclk_n < 4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_bit4", 32'(n >= 400), 0);
    push_burst('{8'h11, 8'h22});
    #2 rst = 1'b1;
    #1;
    chk("abort_sclk", bus.MSPI_SCLK, 0);
    chk("abort_csel", bus.MSPI_CSEL, 1);
    chk("abort_mosi", bus.MSPI_MOSI, 0);
    chk("abort_busy", bus.MSPI_Busy, 0);
    chk("abort_full", bus.MSPI_Tx_Full, 0);
    chk("abort_valid", bus.MSPI_Rx_Valid, 0);
    chk("abort_rx_byte", bus.MSPI_Rx_Byte, 0);
    chk("abort_rx_n", rx_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    mon_clear();
    repeat (300) @(negedge clk);
    chk("abort_no_frame", frame_q.size() + (bus.MSPI_CSEL ? 0 : 1), 0);
    chk("abort_no_sclk", sclk_n, 0);
    chk("abort_no_rx", rx_q.size(), 0);
    chk("abort_idle_busy", bus.MSPI_Busy, 0);
    run_frame("post_rst", '{8'h5A}, '{8'hC3});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
